uart_byte_receiver: RTL



---
 rtl/uart_byte_receiver.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/uart_byte_receiver.sv
// -----------------------------------------------------------------------------
// uart_byte_receiver
//
// Serial front end of the host command path. Deserialises 8N1 UART frames
// arriving on the host-facing rx pin into bytes and hands each good byte to
// the command decoder with a single-cycle ready strobe. Frames whose stop bit
// is sampled low are reported with a single-cycle frame_error strobe.
//
// Ports
//   clock        in   1  system clock, all state on the rising edge
//   reset_n      in   1  asynchronous, active-low reset
//   rx           in   1  asynchronous serial line, idle high
//   byte_out     out  8  last good received byte (first received bit = LSB)
//   byte_ready   out  1  one-cycle pulse, byte_out holds a new valid byte
//   frame_error  out  1  one-cycle pulse, stop bit was sampled low
//   rx_busy      out  1  high whenever the receiver is not idle
//
// Timing (CLKS_PER_BIT clocks per bit, HALF_BIT = CLKS_PER_BIT/2)
//   The start bit is confirmed HALF_BIT clocks after the synchronised falling
//   edge, then every data bit and the stop bit are sampled once, a whole bit
//   period apart, near the middle of the bit. Only one sample is taken per
//   bit; there is no majority vote.
// -----------------------------------------------------------------------------
module uart_byte_receiver #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] byte_out,
    output logic       byte_ready,
    output logic       frame_error,
    output logic       rx_busy
);

    // Bit timing. CLKS_PER_BIT must be at least 4 so that HALF_BIT-1 stays a
    // meaningful (non-negative, non-zero-length) start-bit delay.
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK_WAIT
    } state_e;

    // -------------------------------------------------------------------------
    // Input synchroniser. Both flops reset high so that reset release does not
    // look like a falling edge on an idle line.
    // -------------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_s_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // -------------------------------------------------------------------------
    // Receiver state
    // -------------------------------------------------------------------------
    state_e           state_q,       state_d;
    logic [CNT_W-1:0] cnt_q,         cnt_d;
    logic [2:0]       bit_idx_q,     bit_idx_d;
    logic [7:0]       shift_q,       shift_d;
    logic [7:0]       byte_out_q,    byte_out_d;
    logic             byte_ready_q,  byte_ready_d;
    logic             frame_error_q, frame_error_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            byte_out_q    <= '0;
            byte_ready_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            byte_out_q    <= byte_out_d;
            byte_ready_q  <= byte_ready_d;
            frame_error_q <= frame_error_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic. The strobes default low every cycle, so each one can
    // only ever be high for the single cycle after the stop-bit sample.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        byte_out_d    = byte_out_q;
        byte_ready_d  = 1'b0;
        frame_error_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        // Line still low at mid start bit: a real frame.
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end else begin
                        // Line went back high: glitch, drop it silently.
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d              = '0;
                    shift_d[bit_idx_q] = rx_s_q;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        // Returning to IDLE at mid stop bit lets a start bit
                        // that immediately follows be caught without a gap.
                        byte_out_d   = shift_q;
                        byte_ready_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        frame_error_d = 1'b1;
                        state_d       = S_BREAK_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_BREAK_WAIT: begin
                // Hold here while the line stays low so a break reports one
                // frame error rather than a stream of bogus frames.
                cnt_d = '0;
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign byte_out    = byte_out_q;
    assign byte_ready  = byte_ready_q;
    assign frame_error = frame_error_q;
    assign rx_busy     = (state_q != S_IDLE);

endmodule
